// File: rtl/datapath_pkg.sv
// Shared types for the hazard tracker: register index, pipeline slot records
// and the hard-wired zero register.
package datapath_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic     valid;
        logic     reg_write;
        logic     mem_access;
        reg_idx_t dest;
    } exmem_slot_t;

    typedef struct packed {
        logic     valid;
        logic     reg_write;
        reg_idx_t dest;
    } memwb_slot_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on enable and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/datapath_hazard_tracker.sv
// Tracks EX/MEM and MEM/WB destinations for forwarding and raises stall/bubble
// controls for load-use and memory-wait hazards, with a memory watchdog.
module datapath_hazard_tracker
    import datapath_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ID_valid,
    input  logic [4:0]         ID_src1,
    input  logic [4:0]         ID_src2,
    input  logic               IDEX_valid,
    input  logic               IDEX_RegWrite,
    input  logic               IDEX_MemRead,
    input  logic               IDEX_MemWrite,
    input  logic [4:0]         IDEX_dest,
    input  logic               flush,
    input  logic               mem_ready,
    output logic               EXMEM_RegWrite,
    output logic [4:0]         EXMEM_dest,
    output logic               MEMWB_RegWrite,
    output logic [4:0]         MEMWB_dest,
    output logic               stall_front,
    output logic               stall_ex,
    output logic               bubble_idex,
    output logic               mem_timeout,
    output logic [COUNT_W-1:0] load_use_count,
    output logic [COUNT_W-1:0] mem_stall_count
);

    localparam int WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

    exmem_slot_t     r_exmem;
    memwb_slot_t     r_memwb;
    logic [WD_W-1:0] r_wd_count;
    logic            r_mem_timeout;

    logic            w_mem_stall;
    logic            w_load_use;
    logic            w_ex_valid;
    logic [WD_W-1:0] w_wd_next;

    assign w_mem_stall = r_exmem.valid & r_exmem.mem_access & ~mem_ready;

    assign w_load_use = ID_valid & IDEX_valid & IDEX_MemRead
                      & (IDEX_dest != REG_ZERO)
                      & ((IDEX_dest == ID_src1) | (IDEX_dest == ID_src2));

    assign w_ex_valid = IDEX_valid & ~flush;

    // A stalled EX/MEM keeps its entry; flush only applies on advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_exmem <= '0;
            r_memwb <= '0;
        end else if (w_mem_stall) begin
            r_memwb <= '0;
        end else begin
            r_exmem.valid      <= w_ex_valid;
            r_exmem.reg_write  <= w_ex_valid & IDEX_RegWrite;
            r_exmem.mem_access <= w_ex_valid & (IDEX_MemRead | IDEX_MemWrite);
            r_exmem.dest       <= w_ex_valid ? IDEX_dest : REG_ZERO;
            r_memwb.valid      <= r_exmem.valid;
            r_memwb.reg_write  <= r_exmem.reg_write;
            r_memwb.dest       <= r_exmem.dest;
        end
    end

    always_comb begin
        w_wd_next = '0;
        if (w_mem_stall) begin
            w_wd_next = (r_wd_count == WD_LIMIT) ? r_wd_count : r_wd_count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wd_count    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_wd_count    <= w_wd_next;
            r_mem_timeout <= r_mem_timeout | (w_wd_next == WD_LIMIT);
        end
    end

    sat_counter #(.W(COUNT_W)) u_load_use_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (bubble_idex),
        .o_count (load_use_count)
    );

    sat_counter #(.W(COUNT_W)) u_mem_stall_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_mem_stall),
        .o_count (mem_stall_count)
    );

    assign EXMEM_RegWrite = r_exmem.valid & r_exmem.reg_write;
    assign EXMEM_dest     = r_exmem.dest;
    assign MEMWB_RegWrite = r_memwb.valid & r_memwb.reg_write;
    assign MEMWB_dest     = r_memwb.dest;
    assign stall_front    = w_mem_stall | w_load_use;
    assign stall_ex       = w_mem_stall;
    assign bubble_idex    = w_load_use & ~w_mem_stall;
    assign mem_timeout    = r_mem_timeout;

endmodule

// File: tb/tb_datapath_hazard_tracker.sv
// Self-checking bench: vector table with a forwarding-output scoreboard, then
// hand sequences for memory stalls, watchdog timeout and mid-stall reset.
module tb_datapath_hazard_tracker;

    logic        clock = 1'b0;
    logic        reset;
    logic        ID_valid;
    logic [4:0]  ID_src1, ID_src2;
    logic        IDEX_valid, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite;
    logic [4:0]  IDEX_dest;
    logic        flush, mem_ready;
    logic        EXMEM_RegWrite, MEMWB_RegWrite;
    logic [4:0]  EXMEM_dest, MEMWB_dest;
    logic        stall_front, stall_ex, bubble_idex, mem_timeout;
    logic [15:0] load_use_count, mem_stall_count;

    int checks = 0;
    int failures = 0;

    datapath_hazard_tracker #(.COUNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .ID_valid        (ID_valid),
        .ID_src1         (ID_src1),
        .ID_src2         (ID_src2),
        .IDEX_valid      (IDEX_valid),
        .IDEX_RegWrite   (IDEX_RegWrite),
        .IDEX_MemRead    (IDEX_MemRead),
        .IDEX_MemWrite   (IDEX_MemWrite),
        .IDEX_dest       (IDEX_dest),
        .flush           (flush),
        .mem_ready       (mem_ready),
        .EXMEM_RegWrite  (EXMEM_RegWrite),
        .EXMEM_dest      (EXMEM_dest),
        .MEMWB_RegWrite  (MEMWB_RegWrite),
        .MEMWB_dest      (MEMWB_dest),
        .stall_front     (stall_front),
        .stall_ex        (stall_ex),
        .bubble_idex     (bubble_idex),
        .mem_timeout     (mem_timeout),
        .load_use_count  (load_use_count),
        .mem_stall_count (mem_stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       id_v;
        logic [4:0] s1, s2;
        logic       ex_v, rw, mr, mw;
        logic [4:0] dest;
        logic       fl;
        logic       sf, se, bub;
    } vec_t;

    typedef struct packed {
        logic       rw;
        logic [4:0] dest;
    } exp_t;

    vec_t vecs[16];
    exp_t q_ex[$];
    exp_t q_wb[$];

    function automatic vec_t mk(input logic idv, input logic [4:0] s1, input logic [4:0] s2,
                                input logic exv, input logic rw, input logic mr, input logic mw,
                                input logic [4:0] d, input logic fl,
                                input logic sf, input logic se, input logic bub);
        vec_t v;
        v.id_v = idv; v.s1 = s1; v.s2 = s2;
        v.ex_v = exv; v.rw = rw; v.mr = mr; v.mw = mw;
        v.dest = d; v.fl = fl;
        v.sf = sf; v.se = se; v.bub = bub;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic idle();
        ID_valid = 0; ID_src1 = 0; ID_src2 = 0;
        IDEX_valid = 0; IDEX_RegWrite = 0; IDEX_MemRead = 0; IDEX_MemWrite = 0;
        IDEX_dest = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t e;
        int   n;

        vecs[0]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0,  1, 1, 0, 0, 5,  0, 0, 0, 0);  // ALU -> r5
        vecs[2]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[5]  = mk(1, 1, 3,  1, 1, 1, 0, 3,  0, 1, 0, 1);  // load r3, src2 = r3
        vecs[6]  = mk(1, 1, 3,  0, 0, 0, 0, 0,  0, 0, 0, 0);  // bubble in EX
        vecs[7]  = mk(0, 0, 0,  1, 1, 0, 0, 8,  0, 0, 0, 0);  // dependent op
        vecs[8]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0,  1, 1, 1, 0, 0,  0, 0, 0, 0);  // load r0: no hazard
        vecs[10] = mk(0, 0, 0,  1, 1, 0, 0, 7,  1, 0, 0, 0);  // flushed write r7
        vecs[11] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0,  1, 0, 0, 1, 9,  0, 0, 0, 0);  // store
        vecs[13] = mk(1, 12, 2, 1, 1, 1, 0, 12, 0, 1, 0, 1);  // load r12, src1 = r12
        vecs[14] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0);

        idle();
        mem_ready = 1;
        reset = 1;
        #2;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_exmem_rw", EXMEM_RegWrite, 0);
        chk("rst_memwb_rw", MEMWB_RegWrite, 0);
        chk("rst_stall_front", stall_front, 0);
        chk("rst_stall_ex", stall_ex, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_lu_count", load_use_count, 0);
        reset = 0;

        q_ex.push_back('0);
        q_wb.push_back('0);
        for (int i = 0; i < 16; i++) begin
            ID_valid = vecs[i].id_v; ID_src1 = vecs[i].s1; ID_src2 = vecs[i].s2;
            IDEX_valid = vecs[i].ex_v; IDEX_RegWrite = vecs[i].rw;
            IDEX_MemRead = vecs[i].mr; IDEX_MemWrite = vecs[i].mw;
            IDEX_dest = vecs[i].dest; flush = vecs[i].fl;
            @(negedge clock);
            chk($sformatf("v%0d_stall_front", i), stall_front, vecs[i].sf);
            chk($sformatf("v%0d_stall_ex", i), stall_ex, vecs[i].se);
            chk($sformatf("v%0d_bubble", i), bubble_idex, vecs[i].bub);
            e = q_ex.pop_front();
            chk($sformatf("v%0d_exmem_rw", i), EXMEM_RegWrite, e.rw);
            chk($sformatf("v%0d_exmem_dest", i), EXMEM_dest, e.dest);
            q_wb.push_back(e);
            e = q_wb.pop_front();
            chk($sformatf("v%0d_memwb_rw", i), MEMWB_RegWrite, e.rw);
            chk($sformatf("v%0d_memwb_dest", i), MEMWB_dest, e.dest);
            if (vecs[i].ex_v && !vecs[i].fl)
                e = '{rw: vecs[i].rw, dest: vecs[i].dest};
            else
                e = '0;
            q_ex.push_back(e);
            step();
        end
        idle();
        @(negedge clock);
        chk("table_lu_count", load_use_count, 2);
        chk("table_ms_count", mem_stall_count, 0);
        step();

        // Load r4 with three wait cycles; a dependent load waits behind it.
        IDEX_valid = 1; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_dest = 4;
        step();
        IDEX_dest = 6; ID_valid = 1; ID_src1 = 6; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("ms%0d_stall_ex", i), stall_ex, 1);
            chk($sformatf("ms%0d_stall_front", i), stall_front, 1);
            chk($sformatf("ms%0d_bubble", i), bubble_idex, 0);
            chk($sformatf("ms%0d_exmem_dest", i), EXMEM_dest, 4);
            chk($sformatf("ms%0d_exmem_rw", i), EXMEM_RegWrite, 1);
            chk($sformatf("ms%0d_memwb_rw", i), MEMWB_RegWrite, 0);
            step();
        end
        mem_ready = 1;
        @(negedge clock);
        chk("ms_release_stall_ex", stall_ex, 0);
        chk("ms_release_bubble", bubble_idex, 1);
        chk("ms_release_exmem_dest", EXMEM_dest, 4);
        step();
        idle();
        @(negedge clock);
        chk("ms_memwb_dest", MEMWB_dest, 4);
        chk("ms_memwb_rw", MEMWB_RegWrite, 1);
        chk("ms_exmem_dest", EXMEM_dest, 6);
        chk("ms_count", mem_stall_count, 3);
        chk("ms_lu_count", load_use_count, 3);
        chk("ms_no_timeout", mem_timeout, 0);
        step();

        // Watchdog: hold mem_ready low until the timeout flag rises.
        IDEX_valid = 1; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_dest = 2;
        step();
        idle();
        mem_ready = 0;
        n = 0;
        while (!mem_timeout && n < 10) begin
            step();
            n++;
        end
        chk("wd_cycles_to_timeout", n, 4);
        mem_ready = 1;
        repeat (2) step();
        @(negedge clock);
        chk("wd_sticky", mem_timeout, 1);
        chk("wd_ms_count", mem_stall_count, 7);
        step();

        // Reset arriving mid-stall clears stall state without a clock edge.
        IDEX_valid = 1; IDEX_RegWrite = 1; IDEX_MemRead = 1; IDEX_dest = 11;
        step();
        idle();
        mem_ready = 0;
        @(negedge clock);
        chk("pre_rst_stall_ex", stall_ex, 1);
        #2;
        reset = 1;
        #1;
        chk("async_rst_stall_ex", stall_ex, 0);
        chk("async_rst_stall_front", stall_front, 0);
        chk("async_rst_exmem_dest", EXMEM_dest, 0);
        chk("async_rst_exmem_rw", EXMEM_RegWrite, 0);
        chk("async_rst_timeout", mem_timeout, 0);
        chk("async_rst_ms_count", mem_stall_count, 0);
        chk("async_rst_lu_count", load_use_count, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 0;
        mem_ready = 1;
        step();
        chk("post_rst_exmem_dest", EXMEM_dest, 0);
        chk("post_rst_timeout", mem_timeout, 0);
        IDEX_valid = 1; IDEX_RegWrite = 1; IDEX_dest = 13;
        step();
        idle();
        chk("post_rst_alu_dest", EXMEM_dest, 13);
        chk("post_rst_alu_rw", EXMEM_RegWrite, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
